// File: rtl/cache_pkg.sv
// Shared types and constants for the two-way set-associative cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_WBACK   = 2'd2,
        ST_ALLOC   = 2'd3
    } state_e;

    localparam logic MEM_READ  = 1'b0;
    localparam logic MEM_WRITE = 1'b1;

    localparam int STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cache_way.sv
// One cache way: per-set valid/dirty/tag/data, combinational read at idx.
// Latency: read is combinational; a write lands on the next rising edge.
// Backpressure: none, writes are always accepted.
module cache_way #(
    parameter int SETS   = 8,
    parameter int IDX_W  = 3,
    parameter int TAG_W  = 7,
    parameter int DATA_W = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  idx,
    output logic              rd_valid,
    output logic              rd_dirty,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic              wr_dirty,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [DATA_W-1:0] wr_data
);

    logic [SETS-1:0]   valid_q, valid_d;
    logic [SETS-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [TAG_W-1:0]  tag_d  [SETS];
    logic [DATA_W-1:0] data_q [SETS];
    logic [DATA_W-1:0] data_d [SETS];

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];

    // Every write installs a valid line; clearing dirty rewrites the same tag/data.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (wr_en) begin
            valid_d[idx] = 1'b1;
            dirty_d[idx] = wr_dirty;
            tag_d[idx]   = wr_tag;
            data_d[idx]  = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: rtl/set_assoc_cache.sv
// Two-way set-associative write-back cache, LRU replacement; CACHE_STATS_EN adds hit/miss counters.
// Latency: hit done 1 cycle after accept; miss done 1 cycle after the final mem_ready edge.
// Backpressure: cache_ready low outside IDLE, cpu_req then ignored; mem side waits on mem_ready.
module set_assoc_cache
    import cache_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 20,
    parameter int SETS   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_rw,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_done,
    output logic              cache_ready,
    output logic              mem_req,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef CACHE_STATS_EN
    ,
    output logic [STAT_W-1:0] hit_count,
    output logic [STAT_W-1:0] miss_count
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W;

    state_e            state_q, state_d;
    logic              req_rw_q, req_rw_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic              victim_q, victim_d;
    logic [SETS-1:0]   lru_q, lru_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              cpu_done_q, cpu_done_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_rw_q, mem_rw_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [1:0]        w_valid, w_dirty, hit, way_we;
    logic [TAG_W-1:0]  w_tag  [2];
    logic [DATA_W-1:0] w_data [2];
    logic              wr_dirty;
    logic [TAG_W-1:0]  wr_tag;
    logic [DATA_W-1:0] wr_data;
    logic              hit_way;
    logic              vic;

    assign req_idx = req_addr_q[IDX_W-1:0];
    assign req_tag = req_addr_q[ADDR_W-1:IDX_W];

    for (genvar g = 0; g < 2; g++) begin : g_way
        cache_way #(
            .SETS   (SETS),
            .IDX_W  (IDX_W),
            .TAG_W  (TAG_W),
            .DATA_W (DATA_W)
        ) u_way (
            .clk      (clk),
            .rst_n    (rst_n),
            .idx      (req_idx),
            .rd_valid (w_valid[g]),
            .rd_dirty (w_dirty[g]),
            .rd_tag   (w_tag[g]),
            .rd_data  (w_data[g]),
            .wr_en    (way_we[g]),
            .wr_dirty (wr_dirty),
            .wr_tag   (wr_tag),
            .wr_data  (wr_data)
        );
        assign hit[g] = w_valid[g] && (w_tag[g] == req_tag);
    end

    assign hit_way = hit[1];
    // Fill empty ways in order before evicting the least recently used one.
    assign vic = !w_valid[0] ? 1'b0 : (!w_valid[1] ? 1'b1 : lru_q[req_idx]);

    always_comb begin
        state_d     = state_q;
        req_rw_d    = req_rw_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        victim_d    = victim_q;
        lru_d       = lru_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_done_d  = 1'b0;
        mem_req_d   = mem_req_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        way_we      = 2'b00;
        wr_dirty    = 1'b0;
        wr_tag      = req_tag;
        wr_data     = req_wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    req_rw_d    = cpu_rw;
                    req_addr_d  = cpu_addr;
                    req_wdata_d = cpu_wdata;
                    state_d     = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (|hit) begin
                    if (req_rw_q) begin
                        way_we[hit_way] = 1'b1;
                        wr_dirty        = 1'b1;
                        cpu_rdata_d     = req_wdata_q;
                    end else begin
                        cpu_rdata_d = w_data[hit_way];
                    end
                    lru_d[req_idx] = ~hit_way;
                    cpu_done_d     = 1'b1;
                    state_d        = ST_IDLE;
                end else begin
                    victim_d  = vic;
                    mem_req_d = 1'b1;
                    if (w_valid[vic] && w_dirty[vic]) begin
                        mem_rw_d    = MEM_WRITE;
                        mem_addr_d  = {w_tag[vic], req_idx};
                        mem_wdata_d = w_data[vic];
                        state_d     = ST_WBACK;
                    end else begin
                        mem_rw_d   = MEM_READ;
                        mem_addr_d = req_addr_q;
                        state_d    = ST_ALLOC;
                    end
                end
            end
            ST_WBACK: begin
                if (mem_ready) begin
                    way_we[victim_q] = 1'b1;
                    wr_dirty         = 1'b0;
                    wr_tag           = w_tag[victim_q];
                    wr_data          = w_data[victim_q];
                    mem_rw_d         = MEM_READ;
                    mem_addr_d       = req_addr_q;
                    state_d          = ST_ALLOC;
                end
            end
            ST_ALLOC: begin
                if (mem_ready) begin
                    way_we[victim_q] = 1'b1;
                    wr_dirty         = req_rw_q;
                    wr_data          = req_rw_q ? req_wdata_q : mem_rdata;
                    cpu_rdata_d      = wr_data;
                    lru_d[req_idx]   = ~victim_q;
                    mem_req_d        = 1'b0;
                    cpu_done_d       = 1'b1;
                    state_d          = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_rw_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            victim_q    <= 1'b0;
            lru_q       <= '0;
            cpu_rdata_q <= '0;
            cpu_done_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_rw_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            req_rw_q    <= req_rw_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            victim_q    <= victim_d;
            lru_q       <= lru_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_done_q  <= cpu_done_d;
            mem_req_q   <= mem_req_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_done    = cpu_done_q;
    assign cache_ready = (state_q == ST_IDLE);
    assign mem_req     = mem_req_q;
    assign mem_rw      = mem_rw_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

`ifdef CACHE_STATS_EN
    logic              hit_ev, miss_ev;
    logic [STAT_W-1:0] hit_count_q, hit_count_d;
    logic [STAT_W-1:0] miss_count_q, miss_count_d;

    assign hit_ev  = (state_q == ST_COMPARE) && (|hit);
    assign miss_ev = (state_q == ST_COMPARE) && !(|hit);

    always_comb begin
        hit_count_d  = hit_ev  ? sat_inc(hit_count_q)  : hit_count_q;
        miss_count_d = miss_ev ? sat_inc(miss_count_q) : miss_count_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// Directed bench for set_assoc_cache: hits, clean/dirty misses, LRU victim choice,
// memory stall, and reset during write-back. Memory responses are driven by hand.
module tb_set_assoc_cache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_rw;
    logic [9:0]  cpu_addr;
    logic [19:0] cpu_wdata, cpu_rdata;
    logic        cpu_done, cache_ready;
    logic        mem_req, mem_rw;
    logic [9:0]  mem_addr;
    logic [19:0] mem_wdata, mem_rdata;
    logic        mem_ready;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count, miss_count;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    set_assoc_cache #(.ADDR_W(10), .DATA_W(20), .SETS(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_req     (cpu_req),
        .cpu_rw      (cpu_rw),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_done    (cpu_done),
        .cache_ready (cache_ready),
        .mem_req     (mem_req),
        .mem_rw      (mem_rw),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
`ifdef CACHE_STATS_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present one request for a single edge; on return the cache is in COMPARE.
    task automatic cpu_op(input string tag, input logic rw, input logic [9:0] addr,
                          input logic [19:0] wd);
        @(negedge clk);
        chk({tag, "_ready_before"}, cache_ready, 1);
        cpu_req   = 1'b1;
        cpu_rw    = rw;
        cpu_addr  = addr;
        cpu_wdata = wd;
        @(negedge clk);
        cpu_req = 1'b0;
        chk({tag, "_accepted"}, cache_ready, 0);
    endtask

    task automatic expect_hit(input string tag, input logic [19:0] exp_rdata);
        @(negedge clk);
        chk({tag, "_done"}, cpu_done, 1);
        chk({tag, "_rdata"}, cpu_rdata, exp_rdata);
        chk({tag, "_no_mem"}, mem_req, 0);
        chk({tag, "_ready"}, cache_ready, 1);
    endtask

    // Wait (bounded) for a memory request, check it, optionally stall, then answer.
    task automatic mem_step(input string tag, input logic rw, input logic [9:0] addr,
                            input logic [19:0] wd, input logic [19:0] rd,
                            input int stall, input logic poke, input logic b2b);
        int n;
        @(negedge clk);
        mem_ready = 1'b0;
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_mem_req"}, mem_req, 1);
        if (b2b) chk({tag, "_no_gap"}, n, 0);
        chk({tag, "_mem_rw"}, mem_rw, rw);
        chk({tag, "_mem_addr"}, mem_addr, addr);
        if (rw) chk({tag, "_mem_wdata"}, mem_wdata, wd);
        for (int i = 0; i < stall; i++) begin
            if (poke && i == 2) begin
                cpu_req  = 1'b1;
                cpu_rw   = 1'b0;
                cpu_addr = 10'h0E6;
            end else begin
                cpu_req = 1'b0;
            end
            @(negedge clk);
            chk({tag, "_stall_req"}, mem_req, 1);
            chk({tag, "_stall_addr"}, mem_addr, addr);
            chk({tag, "_stall_rw"}, mem_rw, rw);
            chk({tag, "_stall_ready"}, cache_ready, 0);
        end
        cpu_req   = 1'b0;
        mem_rdata = rd;
        mem_ready = 1'b1;
    endtask

    task automatic expect_fill(input string tag, input logic [19:0] exp_rdata);
        @(negedge clk);
        mem_ready = 1'b0;
        chk({tag, "_done"}, cpu_done, 1);
        chk({tag, "_rdata"}, cpu_rdata, exp_rdata);
        chk({tag, "_mem_idle"}, mem_req, 0);
        chk({tag, "_ready"}, cache_ready, 1);
        @(negedge clk);
        chk({tag, "_done_pulse"}, cpu_done, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cpu_req   = 1'b0;
        cpu_rw    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        #12;
        chk("rst_ready", cache_ready, 1);
        chk("rst_done", cpu_done, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_rw", mem_rw, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
`ifdef CACHE_STATS_EN
        chk("rst_hits", hit_count, 0);
        chk("rst_misses", miss_count, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Cold read miss, then hits on the same word.
        cpu_op("rd025", 1'b0, 10'h025, 20'h0);
        mem_step("rd025", 1'b0, 10'h025, 20'h0, 20'hABCDE, 0, 1'b0, 1'b0);
        expect_fill("rd025", 20'hABCDE);
        cpu_op("rd025h", 1'b0, 10'h025, 20'h0);
        expect_hit("rd025h", 20'hABCDE);
        cpu_op("wr025h", 1'b1, 10'h025, 20'h12345);
        expect_hit("wr025h", 20'h12345);
        cpu_op("rd025h2", 1'b0, 10'h025, 20'h0);
        expect_hit("rd025h2", 20'h12345);

        // Second way of set 5, then LRU eviction of the dirty 0x025 line.
        cpu_op("rd005", 1'b0, 10'h005, 20'h0);
        mem_step("rd005", 1'b0, 10'h005, 20'h0, 20'h00555, 0, 1'b0, 1'b0);
        expect_fill("rd005", 20'h00555);
        cpu_op("rd005h", 1'b0, 10'h005, 20'h0);
        expect_hit("rd005h", 20'h00555);
        cpu_op("rd045", 1'b0, 10'h045, 20'h0);
        mem_step("rd045_wb", 1'b1, 10'h025, 20'h12345, 20'h0, 0, 1'b0, 1'b0);
        mem_step("rd045_fill", 1'b0, 10'h045, 20'h0, 20'h04545, 0, 1'b0, 1'b1);
        expect_fill("rd045", 20'h04545);
        cpu_op("rd005h2", 1'b0, 10'h005, 20'h0);
        expect_hit("rd005h2", 20'h00555);

        // Write miss with a clean victim: read only, line left dirty.
        cpu_op("wr066", 1'b1, 10'h066, 20'h66666);
        mem_step("wr066", 1'b0, 10'h066, 20'h0, 20'hDEAD0, 0, 1'b0, 1'b0);
        expect_fill("wr066", 20'h66666);
        cpu_op("rd0e6", 1'b0, 10'h0E6, 20'h0);
        mem_step("rd0e6", 1'b0, 10'h0E6, 20'h0, 20'h0E6E6, 0, 1'b0, 1'b0);
        expect_fill("rd0e6", 20'h0E6E6);

        // Evict 0x066 with a 10-cycle fill stall and a stray cpu_req during it.
        cpu_op("rd026", 1'b0, 10'h026, 20'h0);
        mem_step("rd026_wb", 1'b1, 10'h066, 20'h66666, 20'h0, 0, 1'b0, 1'b0);
        mem_step("rd026_fill", 1'b0, 10'h026, 20'h0, 20'h02626, 10, 1'b1, 1'b1);
        expect_fill("rd026", 20'h02626);
        chk("stray_req_dropped", cache_ready, 1);

        // Make 0x045 dirty and LRU, then abort its write-back with reset.
        cpu_op("wr045h", 1'b1, 10'h045, 20'h11111);
        expect_hit("wr045h", 20'h11111);
        cpu_op("rd005h3", 1'b0, 10'h005, 20'h0);
        expect_hit("rd005h3", 20'h00555);
        cpu_op("rd085", 1'b0, 10'h085, 20'h0);
        @(negedge clk);
        chk("rd085_wb_req", mem_req, 1);
        chk("rd085_wb_rw", mem_rw, 1);
        chk("rd085_wb_addr", mem_addr, 10'h045);
        chk("rd085_wb_data", mem_wdata, 20'h11111);
`ifdef CACHE_STATS_EN
        chk("stats_hits", hit_count, 7);
        chk("stats_misses", miss_count, 7);
`endif
        rst_n = 1'b0;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_ready", cache_ready, 1);
        chk("arst_done", cpu_done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Previously hitting 0x005 must miss after reset.
        cpu_op("rd005_post", 1'b0, 10'h005, 20'h0);
        mem_step("rd005_post", 1'b0, 10'h005, 20'h0, 20'h0F0F0, 0, 1'b0, 1'b0);
        expect_fill("rd005_post", 20'h0F0F0);
`ifdef CACHE_STATS_EN
        chk("stats_hits_post", hit_count, 0);
        chk("stats_misses_post", miss_count, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
